// File: rtl/pc_fetch_unit.sv
// Program-counter and fetch sequencing for the single-cycle 8-bit core.
// Owns the IDLE/RUN/HALTED state machine, next-PC selection and the run-cycle counter.
module pc_fetch_unit #(
  parameter int PC_W       = 10,
  parameter int START_ADDR = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             branch,
  input  logic [7:0]       boffset,
  input  logic             bsign,
  input  logic             soft_reset,
  input  logic             halt_req,
  output logic [PC_W-1:0]  pc,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] cycle_cnt
);

  // Branch arithmetic runs at max(8, PC_W) so a wide offset is never clipped before the add.
  localparam int AW = (PC_W > 8) ? PC_W : 8;

  localparam logic [PC_W-1:0]  START_PC = PC_W'(START_ADDR);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t           state, stateNext;
  logic [PC_W-1:0]  pcNext;
  logic [CNT_W-1:0] cntNext;

  logic [AW-1:0]    pcExt;
  logic [AW-1:0]    offExt;
  logic [AW-1:0]    targetExt;
  logic [PC_W-1:0]  branchTarget;
  logic [PC_W-1:0]  seqTarget;
  logic [CNT_W-1:0] cntInc;

  always_comb begin
    pcExt        = AW'(pc);
    offExt       = AW'(boffset);
    targetExt    = bsign ? (pcExt - offExt) : (pcExt + offExt);
    branchTarget = targetExt[PC_W-1:0];
    seqTarget    = pc + PC_W'(1);
    cntInc       = (cycle_cnt == CNT_MAX) ? cycle_cnt : (cycle_cnt + CNT_W'(1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      pc        <= START_PC;
      cycle_cnt <= '0;
    end else begin
      state     <= stateNext;
      pc        <= pcNext;
      cycle_cnt <= cntNext;
    end
  end

  // A halting RST leaves PC on the RST address so it can be inspected afterwards.
  always_comb begin
    stateNext = state;
    pcNext    = pc;
    cntNext   = cycle_cnt;
    case (state)
      IDLE, HALTED: begin
        if (start) begin
          stateNext = RUN;
          pcNext    = START_PC;
          cntNext   = '0;
        end
      end
      RUN: begin
        cntNext = cntInc;
        if (soft_reset && halt_req) begin
          stateNext = HALTED;
        end else if (soft_reset) begin
          pcNext = START_PC;
        end else if (branch) begin
          pcNext = branchTarget;
        end else begin
          pcNext = seqTarget;
        end
      end
      default: begin
        stateNext = IDLE;
        pcNext    = START_PC;
        cntNext   = '0;
      end
    endcase
  end

  assign running = (state == RUN);
  assign done    = (state == HALTED);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed testbench for pc_fetch_unit with hand-computed expected values.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        branch;
  logic [7:0]  boffset;
  logic        bsign;
  logic        soft_reset;
  logic        halt_req;
  logic [9:0]  pc;
  logic        running;
  logic        done;
  logic [15:0] cycle_cnt;

  int checks   = 0;
  int failures = 0;
  int expCnt   = 0;
  int frozenCnt;

  always #5 clk = ~clk;

  pc_fetch_unit #(.PC_W(10), .START_ADDR(0), .CNT_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .branch     (branch),
    .boffset    (boffset),
    .bsign      (bsign),
    .soft_reset (soft_reset),
    .halt_req   (halt_req),
    .pc         (pc),
    .running    (running),
    .done       (done),
    .cycle_cnt  (cycle_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then return at the next falling edge.
  task automatic applyStimulus(input logic br, input logic [7:0] off, input logic sg,
                               input logic sr, input logic hr, input logic st);
    branch     = br;
    boffset    = off;
    bsign      = sg;
    soft_reset = sr;
    halt_req   = hr;
    start      = st;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic runStep(input string tag, input logic br, input logic [7:0] off, input logic sg,
                         input logic sr, input logic hr, input logic [31:0] expPc);
    applyStimulus(br, off, sg, sr, hr, 1'b0);
    expCnt++;
    checkOutput({tag, ".pc"}, 32'(pc), expPc);
    checkOutput({tag, ".cnt"}, 32'(cycle_cnt), 32'(expCnt));
  endtask

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    branch     = 1'b0;
    boffset    = 8'd1;
    bsign      = 1'b0;
    soft_reset = 1'b0;
    halt_req   = 1'b0;
    #2;
    checkOutput("reset.pc", 32'(pc), 32'd0);
    checkOutput("reset.running", 32'(running), 32'd0);
    checkOutput("reset.done", 32'(done), 32'd0);
    checkOutput("reset.cnt", 32'(cycle_cnt), 32'd0);

    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("idle.hold.running", 32'(running), 32'd0);

    applyStimulus(1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("start.pc", 32'(pc), 32'd0);
    checkOutput("start.running", 32'(running), 32'd1);
    checkOutput("start.cnt", 32'(cycle_cnt), 32'd0);

    for (int i = 1; i <= 5; i++)
      runStep("seq", 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 32'(i));
    checkOutput("seq.running", 32'(running), 32'd1);
    checkOutput("seq.done", 32'(done), 32'd0);

    runStep("br.to20", 1'b1, 8'd15, 1'b0, 1'b0, 1'b0, 32'd20);
    runStep("br.fwd7", 1'b1, 8'd7, 1'b0, 1'b0, 1'b0, 32'd27);
    runStep("br.back12", 1'b1, 8'd12, 1'b1, 1'b0, 1'b0, 32'd15);
    runStep("br.nottaken", 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 32'd16);
    runStep("br.to3", 1'b1, 8'd13, 1'b1, 1'b0, 1'b0, 32'd3);
    runStep("wrap.back", 1'b1, 8'd5, 1'b1, 1'b0, 1'b0, 32'd1022);
    runStep("wrap.to1023", 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 32'd1023);
    runStep("wrap.fwd", 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 32'd0);
    runStep("br.to40", 1'b1, 8'd40, 1'b0, 1'b0, 1'b0, 32'd40);
    runStep("softrst", 1'b1, 8'd9, 1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("softrst.running", 32'(running), 32'd1);
    runStep("haltreq.ignored", 1'b0, 8'd1, 1'b0, 1'b0, 1'b1, 32'd1);
    checkOutput("haltreq.running", 32'(running), 32'd1);
    runStep("br.to9", 1'b1, 8'd8, 1'b0, 1'b0, 1'b0, 32'd9);
    runStep("halt", 1'b1, 8'd3, 1'b0, 1'b1, 1'b1, 32'd9);
    checkOutput("halt.done", 32'(done), 32'd1);
    checkOutput("halt.running", 32'(running), 32'd0);
    checkOutput("halt.cnt.total", 32'(cycle_cnt), 32'd18);

    frozenCnt = expCnt;
    applyStimulus(1'b1, 8'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("halted.pc", 32'(pc), 32'd9);
    checkOutput("halted.cnt", 32'(cycle_cnt), 32'(frozenCnt));
    checkOutput("halted.done", 32'(done), 32'd1);

    applyStimulus(1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    expCnt = 0;
    checkOutput("restart.pc", 32'(pc), 32'd0);
    checkOutput("restart.cnt", 32'(cycle_cnt), 32'd0);
    checkOutput("restart.running", 32'(running), 32'd1);
    checkOutput("restart.done", 32'(done), 32'd0);

    for (int i = 0; i < 3; i++)
      runStep("selfloop", 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 32'd0);

    runStep("br.to50", 1'b1, 8'd50, 1'b0, 1'b0, 1'b0, 32'd50);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midrst.pc", 32'(pc), 32'd0);
    checkOutput("midrst.running", 32'(running), 32'd0);
    checkOutput("midrst.done", 32'(done), 32'd0);
    checkOutput("midrst.cnt", 32'(cycle_cnt), 32'd0);

    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    start = 1'b0;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    checkOutput("sat.below.cnt", 32'(cycle_cnt), 32'd65534);
    repeat (6) @(posedge clk);
    @(negedge clk);
    checkOutput("sat.cnt", 32'(cycle_cnt), 32'd65535);
    checkOutput("sat.pc", 32'(pc), 32'd4);
    checkOutput("sat.running", 32'(running), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
